imem_loader: RTL

- Hardware program loader for the pipelined CPU's instruction memory.
- Accepts a byte stream over a valid/ready interface and packs bytes into 32-bit little-endian instruction words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the CPU halted (PC pinned at 0) until the load completes plus RELEASE_CYCLES, then releases it. This replaces the bench-side PC forcing with synthesizable sequencing.

---
 rtl/imem_loader.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Hardware program loader for the pipelined CPU's instruction memory.
// A byte stream arrives over a valid/ready interface. Bytes are packed
// little-endian into 32-bit instruction words, and each word is written to
// consecutive word addresses starting at 0. The CPU is held in reset-like
// stall (PC pinned at 0) until the load finishes, plus RELEASE_CYCLES more
// cycles.
//
// Handshake: a byte is transferred on a rising edge when
// i_in_valid & o_in_ready are both high. o_in_ready depends only on loader
// state, never on i_in_valid. The source must hold i_in_data stable while
// i_in_valid is high and the byte has not been taken.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   When the macro is defined, one extra byte follows the payload. That byte
//   must equal the modulo-256 sum of all payload bytes. On a mismatch,
//   o_chk_err and o_done are set, and the CPU is never released. When the
//   macro is undefined, o_chk_err is tied to 0.
//
// Parameters:
//   ADDR_W          word-address width (depth = 2**ADDR_W words)
//   RELEASE_CYCLES  cycles o_cpu_hold stays high after the last write (>= 1)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_start        single-cycle start pulse (honoured in IDLE or DONE only)
//   i_len_words    number of words to load, sampled with i_start
//   i_in_data      stream byte
//   i_in_valid     stream byte valid
//   o_in_ready     loader takes a byte this cycle
//   o_mem_we       instruction-memory write strobe (one cycle per word)
//   o_mem_addr     word address for o_mem_we
//   o_mem_wdata    assembled instruction word
//   o_cpu_hold     1 = CPU stalled with PC forced to 0
//   o_busy         high in RECV, WRITE and RELEASE
//   o_done         sticky completion flag
//   o_len_err      sticky; the requested length was clamped to 2**ADDR_W
//   o_chk_err      checksum mismatch (0 when the checksum feature is absent)
//   o_dbg_state    FSM state: IDLE=0, RECV=1, WRITE=2, RELEASE=3, DONE=4
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W         = 10,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len_words,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_len_err,
    output logic              o_chk_err,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Largest legal length: 2**ADDR_W words.
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    // The release counter runs from 0 to RELEASE_CYCLES-1.
    localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [RC_W-1:0] REL_LAST = RC_W'(RELEASE_CYCLES - 1);

    state_t            r_state;
    logic [ADDR_W:0]   r_len;        // latched (clamped) length in words
    logic [ADDR_W:0]   r_word_idx;   // words written so far; one bit wider than the address
    logic [1:0]        r_byte_idx;   // lane of the next byte
    logic [23:0]       r_word;       // lanes 0..2 of the word under assembly
    logic [RC_W-1:0]   r_rel_cnt;

    logic              w_start_ok;
    logic              w_len_zero;
    logic              w_len_over;
    logic [ADDR_W:0]   w_len_eff;
    logic              w_xfer;
    logic              w_payload_xfer;
    logic [ADDR_W:0]   w_word_next;

    // Start is honoured only while the loader is not busy.
    assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_len_zero  = (i_len_words == '0);
    assign w_len_over  = (i_len_words > MAX_LEN);
    assign w_len_eff   = w_len_over ? MAX_LEN : i_len_words;
    assign w_xfer      = i_in_valid && o_in_ready && (r_state == S_RECV);
    assign w_word_next = r_word_idx + 1'b1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        r_chk_phase;        // the next RECV byte is the checksum
    logic [7:0]  r_sum;
    logic        r_chk_err;
    logic        w_chk_xfer;

    assign w_payload_xfer = w_xfer && !r_chk_phase;
    assign w_chk_xfer     = w_xfer && r_chk_phase;
    assign o_chk_err      = r_chk_err;
`else
    assign w_payload_xfer = w_xfer;
    assign o_chk_err      = 1'b0;
`endif

    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_rel_cnt   <= '0;
            o_in_ready  <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_cpu_hold  <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_len_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk_phase <= 1'b0;
            r_sum       <= '0;
            r_chk_err   <= 1'b0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse, raised on entry to WRITE.
            o_mem_we <= 1'b0;

            if (w_start_ok) begin
                // The same start decode is used from IDLE and from DONE.
                // From DONE, it also clears the sticky flags and re-holds the CPU.
                r_len      <= w_len_eff;
                r_word_idx <= '0;
                r_byte_idx <= '0;
                r_rel_cnt  <= '0;
                o_len_err  <= w_len_over;
                o_done     <= 1'b0;
                o_cpu_hold <= 1'b1;
                o_busy     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_chk_phase <= 1'b0;
                r_sum       <= '0;
                r_chk_err   <= 1'b0;
`endif
                if (w_len_zero) begin
                    r_state    <= S_RELEASE;
                    o_in_ready <= 1'b0;
                end else begin
                    r_state    <= S_RECV;
                    o_in_ready <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_RECV: begin
                        if (w_payload_xfer) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            case (r_byte_idx)
                                2'd0: r_word[7:0]   <= i_in_data;
                                2'd1: r_word[15:8]  <= i_in_data;
                                2'd2: r_word[23:16] <= i_in_data;
                                default: begin
                                    // Lane 3 completes the word. Present it straight
                                    // to memory; WRITE is the cycle the strobe is high.
                                    o_mem_wdata <= {i_in_data, r_word};
                                    o_mem_addr  <= r_word_idx[ADDR_W-1:0];
                                    o_mem_we    <= 1'b1;
                                    o_in_ready  <= 1'b0;
                                    r_state     <= S_WRITE;
                                end
                            endcase
                        end
`ifdef IMEM_LOADER_CHECKSUM_EN
                        if (w_payload_xfer) begin
                            r_sum <= r_sum + i_in_data;
                        end
                        if (w_chk_xfer) begin
                            r_chk_phase <= 1'b0;
                            o_in_ready  <= 1'b0;
                            if (i_in_data == r_sum) begin
                                r_state   <= S_RELEASE;
                                r_rel_cnt <= '0;
                            end else begin
                                // The CPU is never released after a corrupt image:
                                // o_cpu_hold is deliberately left high.
                                r_state   <= S_DONE;
                                o_busy    <= 1'b0;
                                o_done    <= 1'b1;
                                r_chk_err <= 1'b1;
                            end
                        end
`endif
                    end

                    S_WRITE: begin
                        r_word_idx <= w_word_next;
                        if (w_word_next == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            // One more byte is expected: the checksum.
                            r_chk_phase <= 1'b1;
                            r_state     <= S_RECV;
                            o_in_ready  <= 1'b1;
`else
                            r_state     <= S_RELEASE;
                            r_rel_cnt   <= '0;
`endif
                        end else begin
                            r_state    <= S_RECV;
                            o_in_ready <= 1'b1;
                        end
                    end

                    S_RELEASE: begin
                        if (r_rel_cnt == REL_LAST) begin
                            r_state    <= S_DONE;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                        end else begin
                            r_rel_cnt <= r_rel_cnt + 1'b1;
                        end
                    end

                    default: begin
                        // IDLE and DONE wait for a start pulse, which is handled above.
                    end
                endcase
            end
        end
    end

endmodule
